// File: rtl/alu_drv_pkg.sv
// rtl/alu_drv_pkg.sv - shared types and widths for the ALU command driver.
package alu_drv_pkg;

  localparam int STATUS_W = 4;
  localparam int TAG_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } drv_state_t;

  // Response entry minus the K-wide result, which the top prepends once K is known.
  typedef struct packed {
    logic [STATUS_W-1:0] status;
    logic [TAG_W-1:0]    tag;
  } rsp_meta_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - synchronous response FIFO, registered storage, combinational head view.
module alu_rsp_fifo #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 push,
  input  logic [W-1:0]         din,
  input  logic                 pop,
  output logic [W-1:0]         dout,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(D):0]   count
);

  localparam int AW = $clog2(D);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // D is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - issues one command at a time to the ALU and queues its result.
// Define ALU_DRV_TAG_EN to store a wrapping 4-bit sequence tag with each response.
module alu_cmd_driver
  import alu_drv_pkg::*;
#(
  parameter int N   = 4,
  parameter int M   = 8,
  parameter int K   = 8,
  parameter int LAT = 1,
  parameter int D   = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [N-1:0]        i_cmd_op,
  input  logic [M-1:0]        i_cmd_A,
  input  logic [M-1:0]        i_cmd_B,
  output logic [N-1:0]        o_alu_op,
  output logic [M-1:0]        o_alu_A,
  output logic [M-1:0]        o_alu_B,
  input  logic [K-1:0]        i_alu_result,
  input  logic [STATUS_W-1:0] i_alu_status,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [K-1:0]        o_rsp_result,
  output logic [STATUS_W-1:0] o_rsp_status,
  output logic [TAG_W-1:0]    o_rsp_tag
);

  typedef struct packed {
    logic [K-1:0] result;
    rsp_meta_t    meta;
  } rsp_entry_t;

  localparam int ENTRY_W = $bits(rsp_entry_t);
  localparam int CW      = $clog2(D);
  localparam int LW      = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [LW-1:0] WAIT_ONE  = LW'(1);
  localparam logic [LW-1:0] WAIT_LAST = LW'(LAT - 1);
  localparam logic [CW:0]   DEPTH     = (CW+1)'(D);

  drv_state_t       state;
  drv_state_t       state_nxt;
  logic [LW-1:0]    wait_cnt;
  logic [TAG_W-1:0] tag;
  logic             accept;
  logic             push;
  logic             pop;
  rsp_entry_t       push_entry;
  rsp_entry_t       head;
  logic [CW:0]      fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  always_comb begin
    state_nxt   = state;
    o_cmd_ready = 1'b0;
    accept      = 1'b0;
    push        = 1'b0;
    case (state)
      IDLE: begin
        o_cmd_ready = i_reset && (fifo_count < DEPTH);
        accept      = o_cmd_ready && i_cmd_valid;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (wait_cnt == WAIT_LAST) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        push      = !fifo_full;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      o_alu_op <= '0;
      o_alu_A  <= '0;
      o_alu_B  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        o_alu_op <= i_cmd_op;
        o_alu_A  <= i_cmd_A;
        o_alu_B  <= i_cmd_B;
        wait_cnt <= '0;
      end else if (state == ISSUE) begin
        wait_cnt <= wait_cnt + WAIT_ONE;
      end
    end
  end

`ifdef ALU_DRV_TAG_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      tag <= '0;
    end else if (push) begin
      tag <= tag + TAG_W'(1);
    end
  end
`else
  // A constant-zero tag field folds away, leaving no tag storage.
  assign tag = '0;
`endif

  assign push_entry.result      = i_alu_result;
  assign push_entry.meta.status = i_alu_status;
  assign push_entry.meta.tag    = tag;

  alu_rsp_fifo #(
    .W (ENTRY_W),
    .D (D)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push    (push),
    .din     (push_entry),
    .pop     (pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign o_rsp_valid  = i_reset && !fifo_empty;
  assign pop          = o_rsp_valid && i_rsp_ready;
  assign o_rsp_result = head.result;
  assign o_rsp_status = head.meta.status;
  assign o_rsp_tag    = head.meta.tag;

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Initiator side of the ALU op/argument interface. Accepts commands (op, A, B) on a valid/ready stream and drives them onto the ALU input bus. Waits out the ALU's registered latency, then captures result and status into a small response FIFO. That FIFO is drained by a downstream valid/ready stream. Sits between the command source (test sequencer / host) and the ALU; shares i_clk and i_reset with the ALU.

Parameters:
N, 4, op width
M, 8, argument width
K, 8, result width
LAT, 1, ALU clock-edge latency from op/args stable to o_result valid (>=1)
D, 4, response FIFO depth (power of 2, >=2)

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous, active-low reset
i_cmd_valid  input  1  command present
o_cmd_ready  output  1  command accepted when valid&&ready at posedge
i_cmd_op  input  N  operation code
i_cmd_A  input  M  argument A
i_cmd_B  input  M  argument B
o_alu_op  output  N  registered op to ALU
o_alu_A  output  M  registered argument A to ALU
o_alu_B  output  M  registered argument B to ALU
i_alu_result  input  K  ALU result
i_alu_status  input  4  ALU status
o_rsp_valid  output  1  FIFO head valid
i_rsp_ready  input  1  downstream pops head when valid&&ready
o_rsp_result  output  K  head result
o_rsp_status  output  4  head status
o_rsp_tag  output  4  head sequence tag (see optional feature)

Behaviour:
- Reset (i_reset==0 at posedge): state IDLE, wait counter 0, FIFO empty, tag counter 0, o_alu_op/A/B = 0. While i_reset is low, o_cmd_ready=0 and o_rsp_valid=0. o_rsp_result/status/tag = 0 when FIFO empty.
- FSM states: IDLE, ISSUE, CAPTURE.
  - IDLE: o_cmd_ready = (fifo_count < D). On accept: register op/A/B onto o_alu_*; wait counter := 0; go to ISSUE.
  - ISSUE: counter increments each cycle. When counter == LAT-1, go to CAPTURE at that edge.
  - CAPTURE: at the closing edge, push {i_alu_result, i_alu_status, tag} into FIFO; tag increments (mod 16); go to IDLE.
- Latency: command accepted at edge k gives o_rsp_valid high after edge k+LAT+1 (LAT=1: k+2). Throughput: one command per LAT+2 cycles. Exactly one command is in flight at a time.
- o_alu_op/A/B hold their last issued value until the next accept. They are never changed during ISSUE or CAPTURE.
- o_cmd_ready is 0 in ISSUE and CAPTURE.
- FIFO:
  - Registered storage; o_rsp_* is a combinational view of the head entry.
  - Pop on valid&&ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - A push never meets a full FIFO: admission already requires count<D, and only the in-flight command can push.
  - Pointers wrap modulo D. Pop when empty is ignored.
- Reset mid-operation: the in-flight command is discarded (no response) and FIFO contents are flushed.
- The ALU zeroes its outputs during reset. The driver never captures during reset because its FSM is held in IDLE.

Optional Feature:
ALU_DRV_TAG_EN
- Defined: a 4-bit sequence counter is stored with each response and presented on o_rsp_tag. It wraps 15->0 and resets to 0.
- Undefined: no counter and no tag storage; o_rsp_tag is tied to 4'b0000.

Decomposition:
- Package alu_drv_pkg holds:
  - state enum (IDLE, ISSUE, CAPTURE)
  - STATUS_W=4, TAG_W=4
  - response-entry packed struct {result, status, tag}, parameterised by K via the localparam width in the top
- Sub-module alu_rsp_fifo: synchronous FIFO with parameters width and D, ports push/pop/full/empty/count, same reset rule.

Test Plan:
- Reset: hold i_reset=0 for 2 cycles, then release -> o_cmd_ready=1, o_rsp_valid=0, o_alu_op/A/B=0, o_rsp_tag=0.
- Single command: op=4'b0001, A=3, B=5 accepted at edge k; ALU model registers result 8 with status 4'b0000 -> o_alu_op=1, A=3, B=5 from k; o_rsp_valid at k+2 with result 8, status 0, tag 0.
- Backpressure (D=4, i_rsp_ready=0): 5 commands offered -> 4 responses queued, o_cmd_ready stays 0 with count==4. One pop -> 5th command accepted; responses drained in issue order.
- Push/pop same edge: i_rsp_ready=1 continuously with back-to-back commands -> count never exceeds 1; each response appears exactly once.
- Reset mid-op: assert i_reset=0 during CAPTURE -> no response produced, FIFO empty, state IDLE; next command gets tag 0.
- With ALU_DRV_TAG_EN: 17 commands issued -> tags 0..15 then 0. Without the macro: o_rsp_tag==0 always.
